// File: rtl/morse_symbol_sequencer_pkg.sv
// Shared Morse timing constants and sequencer state encoding.
package morse_defs;

  localparam int unsigned DOT_U        = 1;
  localparam int unsigned DASH_U       = 3;
  localparam int unsigned ELEM_GAP_U   = 1;
  localparam int unsigned LETTER_GAP_U = 3;
  localparam int unsigned WORD_GAP_U   = 7;
  localparam int unsigned MAX_ELEM     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARCA    = 2'd1,
    ESP_ELEM = 2'd2,
    ESP_FIN  = 2'd3
  } state_t;

  // Value of the per-state unit counter on the tick that ends a duration of u units.
  function automatic logic [2:0] last_unit_of(input int unsigned u);
    return 3'(u - 1);
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_timer.sv
// Morse unit timer: free-running modulo-UNIDAD counter that pulses tick on its last count.
module morse_unit_timer #(
  parameter logic [27:0] UNIDAD = 28'd12_500_000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [27:0] cnt;

  // Gate with en so that UNIDAD=1 does not report a tick while idle.
  assign tick = en && (cnt == UNIDAD - 28'd1);

  // Count while enabled, wrap to zero on the tick so cnt never exceeds UNIDAD-1.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 28'd1;
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse letter sequencer: plays up to five dots/dashes as a keyed tone followed by a letter or word gap.
module morse_symbol_sequencer
  import morse_defs::*;
#(
  parameter logic [27:0] UNIDAD = 28'd12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] simbolo,
  input  logic [2:0] longitud,
  input  logic       palabra,
  input  logic       valido,
  output logic       listo,
  output logic       tono_en,
  output logic       fin_letra
);

  state_t     state;
  state_t     state_next;
  logic       tick;
  logic       accept;
  logic [2:0] units;
  logic [2:0] limit;
  logic [2:0] idx;
  logic [2:0] eff_len;
  logic [4:0] sym_q;
  logic       pal_q;

  // listo is the registered image of IDLE, so it also blocks the cycle right after reset release.
  assign accept  = listo && valido;
  assign eff_len = (longitud > 3'(MAX_ELEM)) ? 3'(MAX_ELEM) : longitud;

  morse_unit_timer #(.UNIDAD(UNIDAD)) u_timer (
    .clk  (clk),
    .clr  (reset || (state == IDLE)),
    .en   (state != IDLE),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: each timed state leaves on the tick that completes its last unit.
  always_comb begin
    state_next = state;
    limit      = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = (longitud == 3'd0) ? ESP_FIN : MARCA;
      end
      MARCA: begin
        limit = sym_q[idx] ? last_unit_of(DASH_U) : last_unit_of(DOT_U);
        if (tick && units == limit) state_next = (idx == 3'd0) ? ESP_FIN : ESP_ELEM;
      end
      ESP_ELEM: begin
        limit = last_unit_of(ELEM_GAP_U);
        if (tick && units == limit) state_next = MARCA;
      end
      ESP_FIN: begin
        limit = pal_q ? last_unit_of(WORD_GAP_U) : last_unit_of(LETTER_GAP_U);
        if (tick && units == limit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Units elapsed within the current state; cleared on every state change.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state_next != state) units <= '0;
    else if (tick)                                      units <= units + 3'd1;
  end

  // Latch the letter on acceptance and step the element index after each mark.
  always_ff @(posedge clk) begin
    if (accept) begin
      sym_q <= simbolo;
      pal_q <= palabra;
      idx   <= eff_len - 3'd1;
    end else if (state == MARCA && state_next == ESP_ELEM) begin
      idx   <= idx - 3'd1;
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      listo     <= 1'b0;
      tono_en   <= 1'b0;
      fin_letra <= 1'b0;
    end else begin
      listo     <= (state_next == IDLE);
      tono_en   <= (state_next == MARCA);
      fin_letra <= (state == ESP_FIN) && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Bench for morse_symbol_sequencer with UNIDAD=4 against a unit-based timing model.
module tb_morse_symbol_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] simbolo;
  logic [2:0] longitud;
  logic       palabra;
  logic       valido;
  logic       listo;
  logic       tono_en;
  logic       fin_letra;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] q_sym[$];
  int         q_len[$];
  bit         q_pal[$];
  bit         exp_q[$];

  morse_symbol_sequencer #(.UNIDAD(28'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .simbolo   (simbolo),
    .longitud  (longitud),
    .palabra   (palabra),
    .valido    (valido),
    .listo     (listo),
    .tono_en   (tono_en),
    .fin_letra (fin_letra)
  );

  always #5 clk = ~clk;

  // Expected key waveform for one letter, one entry per cycle after acceptance.
  task automatic build_expected(input logic [4:0] s, input int len, input bit pal);
    int n;
    exp_q.delete();
    n = (len > 5) ? 5 : len;
    for (int i = n - 1; i >= 0; i--) begin
      repeat ((s[i] ? 3 : 1) * U) exp_q.push_back(1'b1);
      if (i > 0) repeat (U) exp_q.push_back(1'b0);
    end
    repeat ((pal ? 7 : 3) * U) exp_q.push_back(1'b0);
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (listo !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (listo !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready-timeout: listo=%b required 1", name, listo);
    end
  endtask

  // Plays the queued letters; hold keeps valido high so letters chain back-to-back.
  task automatic run_seq(input string name, input bit hold);
    int n = q_sym.size();
    wait_ready(name);
    for (int i = 0; i < n; i++) begin
      simbolo  = q_sym[i];
      longitud = 3'(q_len[i]);
      palabra  = q_pal[i];
      valido   = 1'b1;
      build_expected(q_sym[i], q_len[i], q_pal[i]);
      for (int c = 0; c < exp_q.size(); c++) begin
        @(negedge clk);
        if (!hold) valido = 1'b0;
        simbolo  = 5'($urandom);
        longitud = 3'($urandom);
        palabra  = 1'($urandom);
        n_checks += 3;
        if (tono_en !== exp_q[c]) begin
          n_fail++;
          $display("FAIL %s tono_en letter %0d cyc %0d: got %b want %b", name, i, c + 1, tono_en, exp_q[c]);
        end
        if (listo !== 1'b0) begin
          n_fail++;
          $display("FAIL %s listo letter %0d cyc %0d: got %b want 0", name, i, c + 1, listo);
        end
        if (fin_letra !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fin_letra early letter %0d cyc %0d: got %b want 0", name, i, c + 1, fin_letra);
        end
      end
      @(negedge clk);
      if (i == n - 1) valido = 1'b0;
      n_checks += 3;
      if (fin_letra !== 1'b1) begin
        n_fail++;
        $display("FAIL %s fin_letra letter %0d cyc %0d: got %b want 1", name, i, exp_q.size() + 1, fin_letra);
      end
      if (listo !== 1'b1) begin
        n_fail++;
        $display("FAIL %s listo at end letter %0d: got %b want 1", name, i, listo);
      end
      if (tono_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s tono_en at end letter %0d: got %b want 0", name, i, tono_en);
      end
      if (!hold && i < n - 1) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          n_checks++;
          if (listo !== 1'b1 || tono_en !== 1'b0 || fin_letra !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle gap: listo=%b tono_en=%b fin_letra=%b want 1/0/0", name, listo, tono_en, fin_letra);
          end
        end
      end
    end
    q_sym.delete();
    q_len.delete();
    q_pal.delete();
  endtask

  task automatic add_letter(input logic [4:0] s, input int len, input bit pal);
    q_sym.push_back(s);
    q_len.push_back(len);
    q_pal.push_back(pal);
  endtask

  task automatic test_reset();
    reset = 1'b1; valido = 1'b0; simbolo = '0; longitud = '0; palabra = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (listo !== 1'b0 || tono_en !== 1'b0 || fin_letra !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: listo=%b tono_en=%b fin_letra=%b want 0/0/0", listo, tono_en, fin_letra);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (listo !== 1'b1) begin
      n_fail++;
      $display("FAIL reset listo after release: got %b want 1", listo);
    end
    repeat (40) begin
      @(negedge clk);
      simbolo = 5'($urandom); longitud = 3'($urandom); palabra = 1'($urandom);
      n_checks++;
      if (listo !== 1'b1 || tono_en !== 1'b0 || fin_letra !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: listo=%b tono_en=%b fin_letra=%b want 1/0/0", listo, tono_en, fin_letra);
      end
    end
  endtask

  task automatic test_letter_a();
    add_letter(5'b00001, 2, 1'b0);
    run_seq("letter_A", 1'b0);
  endtask

  task automatic test_letter_h_word();
    add_letter(5'b00000, 4, 1'b1);
    run_seq("letter_H_word", 1'b0);
  endtask

  task automatic test_empty_word();
    add_letter(5'b10101, 0, 1'b1);
    run_seq("empty_word", 1'b0);
  endtask

  task automatic test_back_to_back();
    add_letter(5'b00000, 1, 1'b0);
    add_letter(5'b00001, 1, 1'b0);
    run_seq("back_to_back_E_T", 1'b1);
  endtask

  task automatic test_long_len();
    add_letter(5'b10110, 7, 1'b0);
    run_seq("longitud7", 1'b0);
  endtask

  task automatic test_reset_mid_letter();
    wait_ready("reset_mid");
    simbolo = 5'b00001; longitud = 3'd2; palabra = 1'b0; valido = 1'b1;
    build_expected(5'b00001, 2, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valido = 1'b0;
      n_checks++;
      if (tono_en !== exp_q[c - 1]) begin
        n_fail++;
        $display("FAIL reset_mid tono_en cyc %0d: got %b want %b", c, tono_en, exp_q[c - 1]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (tono_en !== 1'b0 || listo !== 1'b0 || fin_letra !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid cyc 11: tono_en=%b listo=%b fin_letra=%b want 0/0/0", tono_en, listo, fin_letra);
    end
    for (int c = 12; c <= 45; c++) begin
      @(negedge clk);
      n_checks++;
      if (listo !== 1'b1 || tono_en !== 1'b0 || fin_letra !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid after release cyc %0d: listo=%b tono_en=%b fin_letra=%b want 1/0/0", c, listo, tono_en, fin_letra);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 5; s++) begin
      repeat (5) add_letter(5'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
      run_seq("random", 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_letter_h_word();
    test_empty_word();
    test_back_to_back();
    test_reset_mid_letter();
    test_long_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
